pipelined_csel_adder: RTL and testbench
=======================================

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width; WIDTH multiple of BLOCK, WIDTH>=BLOCK.
REQ-002 SHALL have parameter BLOCK, default 4, carry-select slice width; pipeline depth N = WIDTH/BLOCK.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand transfer request.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry in.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 Stage k (0..N-1) SHALL resolve bits [k*BLOCK +: BLOCK], precomputing both carry-0 and carry-1 slice results, muxed by the carry registered from stage k-1 (stage 0 uses cin).
REQ-015 Each stage SHALL register its resolved sum slice, its carry, a valid bit and the not-yet-consumed upper operand bits; no operand bits beyond the current slice are added combinationally across stages.
REQ-016 Transfer SHALL occur on in_valid && in_ready; output handoff on out_valid && out_ready.
REQ-017 Pipeline advance enable adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational, no dependency on in_valid).
REQ-018 When adv=1 all stages SHALL shift one position; stage 0 loads in_valid; bubbles propagate as valid=0.
REQ-019 When adv=0 all stage registers SHALL hold; sum/cout SHALL remain stable while out_valid && !out_ready.
REQ-020 Latency SHALL be N cycles from accepted input to out_valid with no backpressure; throughput one result per cycle.
REQ-021 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-022 Simultaneous output handoff and input acceptance in one cycle SHALL be legal with full throughput.
REQ-023 sum/cout when out_valid=0 SHALL be don't-care to consumers but deterministic (hold last value).
REQ-024 All-ones + all-ones + 1 SHALL give sum all-ones, cout=1; all-ones + 0 + 1 SHALL wrap to sum 0, cout=1.

Reset
REQ-025 rst_n low SHALL asynchronously clear every stage valid, sum slice and carry register to 0; out_valid=0, sum=0, cout=0.
REQ-026 in_ready SHALL read 1 during and after reset (pipeline empty); assertion mid-operation discards all in-flight operations.
REQ-027 Deassertion SHALL be synchronised externally; first accept possible on first rising edge after release.

Configuration
REQ-028 Macro CSEL_ADDER_OVERFLOW_EN defined: extra output ovf (1 bit) = signed overflow of the two's-complement add, registered alongside cout, reset 0.
REQ-029 Macro absent: port ovf and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package csel_adder_pkg SHALL hold default WIDTH/BLOCK constants and a stage-record typedef (valid, carry, partial sum, pending operands).
REQ-031 One sub-module csel_block SHALL implement a BLOCK-bit dual-ripple slice with carry-select mux, instantiated N times via generate.

Verification
REQ-032 Reset then single op a=16'h6996, b=16'h9669, cin=0 -> after 4 cycles out_valid=1, sum=16'hFFFF, cout=0.
REQ-033 a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1 (carry ripples through all 4 stages).
REQ-034 Back-to-back 8 ops with out_ready=1 -> 8 consecutive out_valid cycles, in-order correct results.
REQ-035 out_ready=0 for 5 cycles with full pipeline -> in_ready=0, sum/cout stable, no loss; resume drains in order.
REQ-036 rst_n low mid-stream with 3 ops in flight -> out_valid=0 immediately, no stale result after release.
REQ-037 With CSEL_ADDER_OVERFLOW_EN: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, ovf=1, cout=0.

Source files
------------

// File: rtl/csel_adder_pkg.sv
// Shared constants and the per-stage pipeline record for the carry-select adder.
// Build with CSEL_ADDER_OVERFLOW_EN defined to add the registered signed-overflow output.
package csel_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_BLOCK = 4;

  // Stage record at the default width; the top re-declares it at its own WIDTH.
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] psum;
    logic [DEFAULT_WIDTH-1:0] pa;
    logic [DEFAULT_WIDTH-1:0] pb;
  } csel_stage_t;

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: two ripple chains (carry-in 0 and 1) and a late select
// on the real carry-in.
module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] s0;
  logic [BLOCK-1:0] s1;
  logic             c0;
  logic             c1;

  always_comb begin
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i] = a[i] ^ b[i] ^ c0;
      c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      s1[i] = a[i] ^ b[i] ^ c1;
      c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1 : c0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// WIDTH/BLOCK-stage pipelined carry-select adder with valid/ready handshake on both sides.
// Optional CSEL_ADDER_OVERFLOW_EN adds a registered signed-overflow output 'ovf'.
module pipelined_csel_adder
  import csel_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int N = WIDTH / BLOCK;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
  } stage_t;

  stage_t st_q [N];
  logic   adv;

  assign adv      = !st_q[N-1].valid || out_ready;
  assign in_ready = adv;

`ifdef CSEL_ADDER_OVERFLOW_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  for (genvar k = 0; k < N; k++) begin : g_stage
    stage_t           src;
    logic [BLOCK-1:0] blk_sum;
    logic             blk_cout;
    logic [WIDTH-1:0] nxt_psum;

    if (k == 0) begin : g_head
      assign src = '{valid: in_valid, carry: cin, psum: '0, pa: a, pb: b};
    end else begin : g_body
      assign src = st_q[k-1];
    end

    // Pending operands are shifted down each stage, so every slice adds the low BLOCK bits.
    csel_block #(.BLOCK(BLOCK)) u_blk (
      .a   (src.pa[BLOCK-1:0]),
      .b   (src.pb[BLOCK-1:0]),
      .cin (src.carry),
      .sum (blk_sum),
      .cout(blk_cout)
    );

    always_comb begin
      nxt_psum = src.psum;
      nxt_psum[k*BLOCK +: BLOCK] = blk_sum;
    end

    // Data only loads with a real operation, so bubbles leave the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q[k] <= '0;
      end else if (adv) begin
        st_q[k].valid <= src.valid;
        if (src.valid) begin
          st_q[k].carry <= blk_cout;
          st_q[k].psum  <= nxt_psum;
          st_q[k].pa    <= src.pa >> BLOCK;
          st_q[k].pb    <= src.pb >> BLOCK;
        end
      end
    end

`ifdef CSEL_ADDER_OVERFLOW_EN
    if (k == N-1) begin : g_ovf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && src.valid) begin
          ovf_q <= (src.pa[BLOCK-1] == src.pb[BLOCK-1]) && (blk_sum[BLOCK-1] != src.pa[BLOCK-1]);
        end
      end
    end
`endif
  end

  assign out_valid = st_q[N-1].valid;
  assign sum       = st_q[N-1].psum;
  assign cout      = st_q[N-1].carry;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed, table-driven bench for pipelined_csel_adder (16-bit, 4-bit slices, 4 stages).
// Define CSEL_ADDER_OVERFLOW_EN for both DUT and bench to also check ovf.
module tb_pipelined_csel_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NV = 10;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CSEL_ADDER_OVERFLOW_EN
  logic        ovf;
`endif

  vec_t vecs [NV];
  int   cmp_count  = 0;
  int   fail_count = 0;

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef CSEL_ADDER_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] va, input logic [15:0] vb, input logic vc);
    in_valid = v;
    a        = va;
    b        = vb;
    cin      = vc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string tag, input int idx);
    checkOutput($sformatf("%s_sum%0d", tag, idx), {16'h0, sum}, {16'h0, vecs[idx].sum});
    checkOutput($sformatf("%s_cout%0d", tag, idx), {31'h0, cout}, {31'h0, vecs[idx].cout});
`ifdef CSEL_ADDER_OVERFLOW_EN
    checkOutput($sformatf("%s_ovf%0d", tag, idx), {31'h0, ovf}, {31'h0, vecs[idx].ovf});
`endif
  endtask

  // Streams vecs[first +: count]; out_ready stays low for the first stall_len cycles a result waits.
  task automatic runStream(input int first, input int count, input int stall_len, input string tag);
    int          sent      = 0;
    int          got       = 0;
    int          hold_cnt  = 0;
    int          gaps      = 0;
    int          cyc       = 0;
    bit          have_held = 1'b0;
    logic [15:0] held_sum  = '0;
    logic        held_cout = 1'b0;
    while (got < count && cyc < 200) begin
      if (sent < count)
        applyStimulus(1'b1, vecs[first+sent].a, vecs[first+sent].b, vecs[first+sent].cin);
      else
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      out_ready = (hold_cnt >= stall_len);
      #1;
      if (out_valid && !out_ready) begin
        if (!have_held) begin
          held_sum  = sum;
          held_cout = cout;
          have_held = 1'b1;
        end else begin
          checkOutput({tag, "_hold_sum"}, {16'h0, sum}, {16'h0, held_sum});
          checkOutput({tag, "_hold_cout"}, {31'h0, cout}, {31'h0, held_cout});
        end
        checkOutput({tag, "_stall_in_ready"}, {31'h0, in_ready}, 32'h0);
        hold_cnt++;
      end
      if (out_valid && out_ready) begin
        checkResult(tag, first + got);
        got++;
      end else if (got > 0 && !out_valid) begin
        gaps++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    out_ready = 1'b1;
    checkOutput({tag, "_received"}, got, count);
    checkOutput({tag, "_gaps"}, gaps, 0);
    checkOutput({tag, "_stall_cycles"}, hold_cnt, stall_len);
  endtask

  initial begin
    int stale;
    int waited;

    vecs[0] = '{16'h6996, 16'h9669, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[9] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    #12;
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_sum", {16'h0, sum}, 32'h0);
    checkOutput("reset_cout", {31'h0, cout}, 32'h0);
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef CSEL_ADDER_OVERFLOW_EN
    checkOutput("reset_ovf", {31'h0, ovf}, 32'h0);
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    // Single operation: accepted on E1, visible after E4, consumed on E5.
    out_ready = 1'b1;
    applyStimulus(1'b1, vecs[0].a, vecs[0].b, vecs[0].cin);
    #1;
    checkOutput("release_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("latency_early%0d", i), {31'h0, out_valid}, 32'h0);
      tick();
    end
    checkOutput("latency_valid", {31'h0, out_valid}, 32'h1);
    checkResult("latency", 0);
    tick();
    checkOutput("drained_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("drained_sum_hold", {16'h0, sum}, 32'h0000FFFF);

    runStream(0, NV, 0, "b2b");
    runStream(2, 6, 5, "bp");

    // Reset with three operations in flight, one of them already at the output.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, vecs[4+i].a, vecs[4+i].b, vecs[4+i].cin);
      tick();
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    out_ready = 1'b0;
    tick();
    checkOutput("pre_reset_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midreset_sum", {16'h0, sum}, 32'h0);
    checkOutput("midreset_cout", {31'h0, cout}, 32'h0);
    checkOutput("midreset_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stale++;
    end
    checkOutput("post_reset_stale", stale, 0);

    applyStimulus(1'b1, vecs[8].a, vecs[8].b, vecs[8].cin);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    waited = 1;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("recovery_latency", waited, 4);
    checkResult("recovery", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
